// File: rtl/sr_branch_pkg.sv
// Shared definitions for the schoolRISCV branch / PC stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sr_branch_pkg;

    // B-type funct3 condition codes
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        RUN  = 1'b0,
        TRAP = 1'b1
    } state_t;

endpackage

// File: rtl/sr_branch_cond.sv
// Branch condition evaluation from ALU flags, keyed on funct3.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs every cycle.
// Ports: funct3 (condition code), alu_zero (ALU zero flag),
//        alu_lt (ALU result[0] for SLT/SLTU), cond (condition true).
module sr_branch_cond
    import sr_branch_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       alu_zero,
    input  logic       alu_lt,
    output logic       cond
);

    always_comb begin
        cond = 1'b0;
        case (funct3)
            F3_BEQ:           cond = alu_zero;
            F3_BNE:           cond = !alu_zero;
            F3_BLT,  F3_BLTU: cond = alu_lt;
            F3_BGE,  F3_BGEU: cond = !alu_lt;
            // 010 / 011 are not branch encodings: never taken
            default:          cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/sr_branch_pc.sv
// PC register, branch resolution, misaligned-target trap FSM and branch stats.
// Latency: taken/pc_plus4 combinational; redirect visible on pc one edge later.
// Backpressure: stall holds PC, state and counters; trap_clear overrides stall.
// Ports: clk/rst_n (async active-low), stall, branch, funct3, alu_zero,
//        alu_lt, imm_b, trap_clear in; pc, pc_plus4, taken, trap, trap_pc,
//        branch_cnt, taken_cnt out.
module sr_branch_pc
    import sr_branch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int          CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             branch,
    input  logic [2:0]       funct3,
    input  logic             alu_zero,
    input  logic             alu_lt,
    input  logic [31:0]      imm_b,
    input  logic             trap_clear,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             taken,
    output logic             trap,
    output logic [31:0]      trap_pc,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [31:0]      r_pc;
    logic [31:0]      r_trap_pc;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_taken_cnt;

    logic             w_cond;
    logic             w_run;
    logic             w_taken;
    logic [31:0]      w_target;
    logic [31:0]      w_pc_plus4;
    logic             w_misalign;
    logic             w_adv;        // RUN and not stalled: this edge commits
    logic             w_fault;      // taken branch to a misaligned target
    logic             w_clear;      // leaving TRAP this edge

    sr_branch_cond u_cond (
        .funct3   (funct3),
        .alu_zero (alu_zero),
        .alu_lt   (alu_lt),
        .cond     (w_cond)
    );

    assign w_run      = (r_state == RUN);
    assign w_taken    = branch & w_cond & w_run;
    assign w_target   = r_pc + imm_b;        // modulo 2^32
    assign w_pc_plus4 = r_pc + 32'd4;        // modulo 2^32
    assign w_misalign = |w_target[1:0];
    assign w_adv      = w_run & !stall;
    assign w_fault    = w_adv & w_taken & w_misalign;
    assign w_clear    = (r_state == TRAP) & trap_clear;

    // FSM next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     if (w_fault)    w_state_nxt = TRAP;
            TRAP:    if (trap_clear) w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // PC register: on a fault the PC holds so trap_pc and pc both point at
    // the faulting branch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_VECTOR;
        end else if (w_clear) begin
            r_pc <= TRAP_VECTOR;
        end else if (w_adv && !w_fault) begin
            r_pc <= w_taken ? w_target : w_pc_plus4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trap_pc <= 32'd0;
        end else if (w_fault) begin
            r_trap_pc <= r_pc;
        end
    end

    // Saturating statistics; a faulting branch still counts as executed+taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_branch_cnt <= '0;
            r_taken_cnt  <= '0;
        end else begin
            if (w_adv && branch && (r_branch_cnt != CNT_MAX)) begin
                r_branch_cnt <= r_branch_cnt + CNT_ONE;
            end
            if (w_adv && w_taken && (r_taken_cnt != CNT_MAX)) begin
                r_taken_cnt <= r_taken_cnt + CNT_ONE;
            end
        end
    end

    assign pc         = r_pc;
    assign pc_plus4   = w_pc_plus4;
    assign taken      = w_taken;
    assign trap       = (r_state == TRAP);
    assign trap_pc    = r_trap_pc;
    assign branch_cnt = r_branch_cnt;
    assign taken_cnt  = r_taken_cnt;

endmodule
